// File: rtl/header_server_pkg.sv
// Shared constants for the block-header server and the double-SHA-256 core:
// word map geometry, SHA-256 padding words for the second message block.
package header_server_pkg;

    localparam int ADDR_W         = 5;
    localparam int HDR_WORDS      = 20;
    localparam int HDR_NONCE_WORD = 19;
    localparam int HDR_NUM_BYTES  = 80;

    localparam logic [31:0] PAD_ONE = 32'h8000_0000;
    localparam logic [31:0] LEN_640 = 32'h0000_0280;

    localparam logic [ADDR_W-1:0] PAD_ONE_ADDR = ADDR_W'(HDR_WORDS);
    localparam logic [ADDR_W-1:0] LEN_ADDR     = '1;

    typedef enum logic {
        LD_IDLE,
        LD_LOADING
    } load_state_e;

    // Constant padding words of block 2; header addresses return zero here.
    function automatic logic [31:0] pad_word(input logic [ADDR_W-1:0] addr);
        logic [31:0] word;
        word = 32'h0;
        if (addr == PAD_ONE_ADDR) word = PAD_ONE;
        if (addr == LEN_ADDR)     word = LEN_640;
        return word;
    endfunction

    function automatic logic [31:0] byte_swap32(input logic [31:0] w);
        return {w[7:0], w[15:8], w[23:16], w[31:24]};
    endfunction

endpackage

// File: rtl/header_server_if.sv
// Word read bus between the double-SHA-256 core (master) and the header server (slave).
interface header_server_if;
    import header_server_pkg::*;

    logic              rq;
    logic [ADDR_W-1:0] addr;
    logic [31:0]       data;
    logic              rdy;

    modport master (output rq, output addr, input data, input rdy);
    modport slave  (input rq, input addr, output data, output rdy);

endinterface

// File: rtl/header_nonce_ctr.sv
// Nonce register: byte-lane load from the header stream, increment between
// hash attempts, and a sticky flag recording a 0xFFFFFFFF -> 0 roll-over.
module header_nonce_ctr (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        byte_we,
    input  logic [1:0]  byte_lane,
    input  logic [7:0]  byte_in,
    input  logic        inc,
    input  logic        clr_wrap,
    output logic [31:0] nonce,
    output logic        wrap
);

    logic [31:0] nonce_q;
    logic        wrap_q;

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            nonce_q <= 32'h0;
            wrap_q  <= 1'b0;
        end else begin
            if (byte_we) begin
                nonce_q[{byte_lane, 3'b000} +: 8] <= byte_in;
            end else if (inc) begin
                nonce_q <= nonce_q + 32'd1;
            end

            if (clr_wrap) begin
                wrap_q <= 1'b0;
            end else if (inc && (&nonce_q)) begin
                wrap_q <= 1'b1;
            end
        end
    end

    assign nonce = nonce_q;
    assign wrap  = wrap_q;

endmodule

// File: rtl/header_server.sv
// Serves the 80-byte block header plus block-2 SHA-256 padding on the word read
// bus; loads the header byte-serially and owns the nonce counter.
module header_server
    import header_server_pkg::*;
#(
    parameter int NONCE_WORD = HDR_NONCE_WORD,
    parameter int HDR_BYTES  = HDR_NUM_BYTES
) (
    input  logic                    clk,
    input  logic                    rst_n,
    header_server_if.slave          bus,
    input  logic                    load_start,
    input  logic                    load_valid,
    input  logic [7:0]              load_byte,
    output logic                    header_valid,
    input  logic                    nonce_inc,
    output logic [31:0]             nonce,
    output logic                    nonce_wrap
);

    localparam int CNT_W    = $clog2(HDR_BYTES);
    localparam int RAM_BYTES = NONCE_WORD * 4;

    localparam logic [CNT_W-1:0]  LAST_BYTE  = CNT_W'(HDR_BYTES - 1);
    localparam logic [CNT_W-1:0]  NONCE_BASE = CNT_W'(RAM_BYTES);
    localparam logic [ADDR_W-1:0] NONCE_ADDR = ADDR_W'(NONCE_WORD);
    localparam logic [ADDR_W-1:0] HDR_END    = ADDR_W'(HDR_WORDS);

    load_state_e      state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             header_valid_q, header_valid_d;
    logic             byte_wr;

    logic [7:0]       hdr_mem [RAM_BYTES];

    logic             nonce_we;
    logic             nonce_inc_ok;

    logic [31:0]      rd_word;
    logic             rd_stall;
    logic [CNT_W-1:0] rd_base;

    logic [31:0]      data_q;
    logic             rdy_q;

    // ------------------------------------------------------------------
    // Load engine
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= LD_IDLE;
            cnt_q          <= '0;
            header_valid_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            header_valid_q <= header_valid_d;
        end
    end

    // NOTE: every output of this block gets a default first so no latch is inferred.
    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        header_valid_d = header_valid_q;
        byte_wr        = 1'b0;

        if (load_start) begin
            state_d        = LD_LOADING;
            cnt_d          = '0;
            header_valid_d = 1'b0;
        end else begin
            unique case (state_q)
                LD_IDLE: ;
                LD_LOADING: begin
                    if (load_valid) begin
                        byte_wr = 1'b1;
                        cnt_d   = cnt_q + CNT_W'(1);
                        if (cnt_q == LAST_BYTE) begin
                            state_d        = LD_IDLE;
                            header_valid_d = 1'b1;
                        end
                    end
                end
                default: state_d = LD_IDLE;
            endcase
        end
    end

    // NOTE: the header RAM is cleared on reset because stale bytes must never be served.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < RAM_BYTES; i++) begin
                hdr_mem[i] <= 8'h00;
            end
        end else if (byte_wr && (cnt_q < NONCE_BASE)) begin
            hdr_mem[cnt_q] <= load_byte;
        end
    end

    // ------------------------------------------------------------------
    // Nonce
    // ------------------------------------------------------------------
    assign nonce_we     = byte_wr && (cnt_q >= NONCE_BASE);
    assign nonce_inc_ok = nonce_inc && header_valid_q && !load_start;

    header_nonce_ctr u_nonce_ctr (
        .clk       (clk),
        .rst_n     (rst_n),
        .byte_we   (nonce_we),
        .byte_lane (cnt_q[1:0]),
        .byte_in   (load_byte),
        .inc       (nonce_inc_ok),
        .clr_wrap  (load_start),
        .nonce     (nonce),
        .wrap      (nonce_wrap)
    );

    // ------------------------------------------------------------------
    // Read bus
    // ------------------------------------------------------------------
    assign rd_base = CNT_W'({bus.addr, 2'b00});

    // Header words stall until a full load; padding words are always served.
    always_comb begin
        rd_word  = pad_word(bus.addr);
        rd_stall = 1'b0;
        if (bus.addr < HDR_END) begin
            rd_stall = !header_valid_q;
            if (bus.addr == NONCE_ADDR) begin
                rd_word = byte_swap32(nonce);
            end else begin
                rd_word = {hdr_mem[rd_base],
                           hdr_mem[rd_base + CNT_W'(1)],
                           hdr_mem[rd_base + CNT_W'(2)],
                           hdr_mem[rd_base + CNT_W'(3)]};
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q <= 32'h0;
            rdy_q  <= 1'b0;
        end else if (bus.rq && !rd_stall) begin
            data_q <= rd_word;
            rdy_q  <= 1'b1;
        end else begin
            rdy_q  <= 1'b0;
        end
    end

    assign bus.data     = data_q;
    assign bus.rdy      = rdy_q;
    assign header_valid = header_valid_q;

endmodule

// File: tb/tb_header_server.sv
// Directed and randomized checks of header_server against a byte-array model
// of the header, load sequence and nonce arithmetic.
module tb_header_server;

    logic        clk;
    logic        rst_n;
    logic        load_start;
    logic        load_valid;
    logic [7:0]  load_byte;
    logic        header_valid;
    logic        nonce_inc;
    logic [31:0] nonce;
    logic        nonce_wrap;

    header_server_if bus ();

    header_server dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .bus          (bus),
        .load_start   (load_start),
        .load_valid   (load_valid),
        .load_byte    (load_byte),
        .header_valid (header_valid),
        .nonce_inc    (nonce_inc),
        .nonce        (nonce),
        .nonce_wrap   (nonce_wrap)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int vectors    = 0;
    int miscompares = 0;

    // Reference model: header as plain bytes, nonce derived from bytes 76..79.
    logic [7:0]  hdr_m [80];
    int          cnt_m;
    bit          loading_m;
    bit          valid_m;
    bit          wrap_m;
    logic        exp_rdy;
    logic [31:0] exp_data;
    logic [7:0]  stim [80];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] nonce_m();
        return {hdr_m[79], hdr_m[78], hdr_m[77], hdr_m[76]};
    endfunction

    function automatic logic [31:0] word_m(input int a);
        if (a < 20) return {hdr_m[4*a], hdr_m[4*a+1], hdr_m[4*a+2], hdr_m[4*a+3]};
        if (a == 20) return 32'h8000_0000;
        if (a == 31) return 32'h0000_0280;
        return 32'h0;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 80; i++) hdr_m[i] = 8'h00;
        cnt_m = 0; loading_m = 0; valid_m = 0; wrap_m = 0;
        exp_rdy = 1'b0; exp_data = 32'h0;
    endtask

    // Advance the model by one clock using the inputs about to be sampled.
    task automatic model_step();
        logic [31:0] n;
        if (bus.rq) begin
            if (int'(bus.addr) < 20 && !valid_m) exp_rdy = 1'b0;
            else begin
                exp_rdy  = 1'b1;
                exp_data = word_m(int'(bus.addr));
            end
        end else begin
            exp_rdy = 1'b0;
        end

        if (load_start) begin
            cnt_m = 0; valid_m = 0; wrap_m = 0; loading_m = 1;
        end else if (loading_m && load_valid) begin
            hdr_m[cnt_m] = load_byte;
            if (cnt_m == 79) begin
                loading_m = 0;
                valid_m   = 1;
            end
            cnt_m++;
        end else if (nonce_inc && valid_m) begin
            n = nonce_m() + 32'd1;
            if (n == 32'h0) wrap_m = 1;
            {hdr_m[79], hdr_m[78], hdr_m[77], hdr_m[76]} = n;
        end
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_state(input string tag);
        check({tag, "/rdy"},   32'(bus.rdy),      32'(exp_rdy));
        check({tag, "/data"},  bus.data,          exp_data);
        check({tag, "/hv"},    32'(header_valid), 32'(valid_m));
        check({tag, "/nonce"}, nonce,             nonce_m());
        check({tag, "/wrap"},  32'(nonce_wrap),   32'(wrap_m));
    endtask

    task automatic read1(input int a);
        bus.rq   = 1'b1;
        bus.addr = 5'(a);
        tick();
    endtask

    task automatic idle_bus();
        bus.rq = 1'b0;
        tick();
    endtask

    task automatic load_stim(input int n, input bit gaps);
        load_start = 1'b1;
        tick();
        load_start = 1'b0;
        for (int i = 0; i < n;) begin
            load_valid = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
            load_byte  = load_valid ? stim[i] : 8'($urandom);
            if (load_valid) i++;
            tick();
            check("load/hv", 32'(header_valid), 32'(valid_m));
        end
        load_valid = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        load_start = 1'b0; load_valid = 1'b0; load_byte = 8'h00; nonce_inc = 1'b0;
        bus.rq = 1'b0; bus.addr = '0;
        model_reset();
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;

        // Reset values
        check("reset/rdy",  32'(bus.rdy), 32'h0);
        check("reset/data", bus.data, 32'h0);
        check("reset/hv",   32'(header_valid), 32'h0);
        check("reset/wrap", 32'(nonce_wrap), 32'h0);

        // Padding served before any load; header words stall
        read1(20); check("pad20", bus.data, 32'h8000_0000); check("pad20/rdy", 32'(bus.rdy), 32'h1);
        read1(25); check("pad25", bus.data, 32'h0);         check("pad25/rdy", 32'(bus.rdy), 32'h1);
        read1(31); check("pad31", bus.data, 32'h0000_0280); check("pad31/rdy", 32'(bus.rdy), 32'h1);
        read1(5);  check("stall5/rdy", 32'(bus.rdy), 32'h0);
        idle_bus(); check_state("idle0");

        // Ascending header 0x00..0x4F
        for (int i = 0; i < 80; i++) stim[i] = 8'(i);
        load_stim(80, 1'b0);
        check("asc/hv", 32'(header_valid), 32'h1);
        check("asc/nonce", nonce, 32'h4F4E_4D4C);
        idle_bus();
        read1(0);  check("asc/a0", bus.data, 32'h0001_0203); check("asc/a0rdy", 32'(bus.rdy), 32'h1);
        idle_bus(); check("asc/rdy_drop", 32'(bus.rdy), 32'h0);
        read1(19); check("asc/a19", bus.data, 32'h4C4D_4E4F);

        // Held rq with stepping address
        read1(0); check("stream0", bus.data, 32'h0001_0203); check("stream0/rdy", 32'(bus.rdy), 32'h1);
        read1(1); check("stream1", bus.data, 32'h0405_0607); check("stream1/rdy", 32'(bus.rdy), 32'h1);
        read1(2); check("stream2", bus.data, 32'h0809_0A0B); check("stream2/rdy", 32'(bus.rdy), 32'h1);
        idle_bus(); check_state("stream_end");

        // Nonce wrap
        for (int i = 76; i < 80; i++) stim[i] = 8'hFF;
        load_stim(80, 1'b1);
        check("wrap/pre", nonce, 32'hFFFF_FFFF);
        nonce_inc = 1'b1; tick(); nonce_inc = 1'b0;
        check("wrap/nonce", nonce, 32'h0);
        check("wrap/flag", 32'(nonce_wrap), 32'h1);
        read1(19); check("wrap/a19", bus.data, 32'h0);
        idle_bus();
        load_start = 1'b1; tick(); load_start = 1'b0;
        check("wrap/clear", 32'(nonce_wrap), 32'h0);
        check_state("wrap_end");

        // Restart and byte both asserted: byte dropped
        load_start = 1'b1; load_valid = 1'b1; load_byte = 8'hAA; tick();
        load_start = 1'b0; load_valid = 1'b0;
        check_state("restart_drop");

        // Aborted load at byte 40, then full reload with 0xFF-i
        for (int i = 0; i < 80; i++) stim[i] = 8'(8'hFF - i);
        load_stim(40, 1'b0);
        load_stim(79, 1'b0);
        check("abort/hv79", 32'(header_valid), 32'h0);
        load_valid = 1'b1; load_byte = stim[79]; tick(); load_valid = 1'b0;
        check("abort/hv80", 32'(header_valid), 32'h1);
        read1(0); check("abort/a0", bus.data, 32'hFFFE_FDFC);

        // Increment in the same cycle as a nonce-word read
        bus.addr = 5'd19; nonce_inc = 1'b1; tick(); nonce_inc = 1'b0;
        check("inc_rd/a19", bus.data, 32'hB3B2_B1B0);
        check("inc_rd/nonce", nonce, 32'hB0B1_B2B4);
        idle_bus(); check_state("inc_rd_end");

        // Randomized headers and traffic
        for (int r = 0; r < 4; r++) begin
            for (int i = 0; i < 80; i++) stim[i] = 8'($urandom);
            if (r == 3) for (int i = 76; i < 80; i++) stim[i] = 8'hFF;
            load_stim(80, 1'b1);
            for (int c = 0; c < 60; c++) begin
                bus.rq    = ($urandom_range(0, 3) != 0);
                bus.addr  = 5'($urandom);
                nonce_inc = ($urandom_range(0, 4) == 0);
                tick();
                check_state("rand");
            end
            nonce_inc = 1'b0;
            idle_bus();
        end

        // Asynchronous reset during a read
        bus.rq = 1'b1; bus.addr = 5'd3; tick();
        check("prereset/rdy", 32'(bus.rdy), 32'h1);
        #2 rst_n = 1'b0;
        #1;
        check("arst/rdy", 32'(bus.rdy), 32'h0);
        check("arst/hv",  32'(header_valid), 32'h0);
        check("arst/nonce", nonce, 32'h0);
        model_reset();
        #2 rst_n = 1'b1;
        @(posedge clk); #1;
        for (int a = 0; a < 20; a++) begin
            read1(a);
            check("post_rst/stall", 32'(bus.rdy), 32'h0);
        end
        idle_bus(); check_state("final");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/header_server.md
Name: header_server

Overview:
- Bus responder holding one 80-byte Bitcoin block header; answers the 32-word rq/addr/rdy/data read bus driven by the double-SHA-256 block.
- Serves header words 0..19 big-endian, with SHA-256 padding for block 2 at words 20..31.
- Loaded byte-serially from the host-side input path.
- Owns the nonce counter: increments it on request between hash attempts and flags wrap-around.

Parameters:
- NONCE_WORD, 19, word index of the nonce within the header (bytes 76..79).
- HDR_BYTES, 80, header length in bytes loaded per load sequence.

Ports:
- clk  input  1  clock
- rst_n  input  1  asynchronous active-low reset
- rq  input  1  read request from initiator, held until rdy seen
- addr  input  5  word address 0..31
- data  output  32  read word, valid when rdy=1
- rdy  output  1  read response valid
- load_start  input  1  pulse: begin new header load
- load_valid  input  1  load_byte valid this cycle
- load_byte  input  8  header byte, wire order (byte 0 first)
- header_valid  output  1  all 80 bytes loaded
- nonce_inc  input  1  pulse: advance nonce
- nonce  output  32  current nonce as little-endian integer (header bytes 79..76)
- nonce_wrap  output  1  sticky: nonce wrapped 0xFFFFFFFF->0

Behaviour:
Clock and reset:
- Single clock. Reset is asynchronous and active-low.
- Reset values: data=0, rdy=0, header_valid=0, nonce_wrap=0, byte counter=0, storage=0.

Read bus (registered, one-cycle latency):
- Each cycle with rq=1, the word for addr is computed. The next cycle presents data and drives rdy=1.
- rdy=1 is repeated every cycle while rq stays high; rdy=0 the cycle after rq=0.
- The initiator re-samples addr each cycle. A changed addr under held rq returns the new word next cycle.
- Word map:
  - addr 0..18: stored bytes {b[4a], b[4a+1], b[4a+2], b[4a+3]}.
  - addr 19: {b76, b77, b78, b79}, taken from the nonce register.
  - addr 20: 0x80000000.
  - addr 31: 0x00000280.
  - addr 21..30: 0x00000000.
- While header_valid=0, requests to addr 0..19 get rdy=0 (stall, no data). Padding words 20..31 are always served.

Load engine, states IDLE, LOADING:
- load_start in any state: byte counter=0, header_valid=0, nonce_wrap=0, state→LOADING.
- In LOADING, each load_valid writes load_byte to byte[counter] and increments counter.
  - Bytes 76..79 write the nonce register: byte 76 = bits 7:0, byte 79 = bits 31:24.
- When the byte at counter=79 is written: header_valid=1 the following cycle, state→IDLE.
- load_valid in IDLE is ignored.
- load_start and load_valid in the same cycle: the restart wins and the byte is dropped.

Nonce:
- nonce_inc with header_valid=1: nonce←nonce+1 (mod 2^32). On 0xFFFFFFFF→0, set nonce_wrap=1 (sticky until load_start or reset).
- nonce_inc while LOADING or header_valid=0 is ignored.
- nonce_inc and a read of addr 19 in the same cycle: the read returns the pre-increment value.

Reset mid-operation:
- All state clears and rdy drops immediately (asynchronous).
- An in-flight read is abandoned; the initiator must restart.

Decomposition:
- Shared package holds:
  - padding constants PAD_ONE=0x80000000 and LEN_640=0x00000280;
  - header word count 20 and the nonce word index;
  - the address width (5).
  The same constants are used by the double-SHA-256 block.
- One natural sub-module: header_nonce_ctr. It holds the 32-bit nonce register with byte-lane load, increment and sticky wrap.
- Header RAM and read mux stay in the top.

Test Plan:
- Reset then load bytes 0x00..0x4F; read addr 0 → data=0x00010203, rdy one cycle after rq. Read addr 19 → 0x4C4D4E4F, nonce=0x4F4E4D4C.
- Read addr 20, 25, 31 with header_valid=0 → 0x80000000, 0x00000000, 0x00000280, each with rdy=1. Read addr 5 before load completes → rdy stays 0.
- Load nonce bytes FF FF FF FF, pulse nonce_inc → nonce=0, addr 19 reads 0x00000000, nonce_wrap=1. Then load_start → nonce_wrap=0.
- Hold rq while stepping addr 0→1→2 on consecutive cycles → data sequence 0x00010203, 0x04050607, 0x08090A0B on consecutive cycles with rdy continuously 1.
- load_start at byte 40 of a load, then full reload with bytes 0xFF−i → header_valid only after the 80th new byte; addr 0 reads 0xFFFEFDFC.
- Assert rst_n=0 mid-read with rq=1 → rdy=0 and header_valid=0 immediately. After release, reads of addr 0..19 stall.
